// File: rtl/reg_cmd_sequencer.sv
// Command sequencer for the function-select register: turns one accepted command
// into a train of per-cycle enable pulses on the register's FunSel/data_in/enable inputs.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high unless in reset
// ISSUE | command in flight; one issue per cycle unless held or aborted
module reg_cmd_sequencer #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_count,
    input  logic          hold,
    input  logic          abort,
    output logic [1:0]    reg_funsel,
    output logic [N-1:0]  reg_data,
    output logic          reg_enable,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [1:0]    funsel_q, funsel_d;
    logic [N-1:0]  data_q, data_d;
    logic          done_q, done_d;
    logic          accept;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign reg_enable = (state_q == ISSUE) && !hold && !abort;
    assign busy       = (state_q == ISSUE);
    assign done       = done_q;
    assign reg_funsel = funsel_q;
    assign reg_data   = data_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        funsel_d    = funsel_q;
        data_d      = data_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ISSUE;
                    funsel_d = cmd_op;
                    data_d   = cmd_data;
                    // load/clear issue once; a zero repeat count still issues once
                    if (cmd_op[1] || (cmd_count == '0)) begin
                        remaining_d = CW'(1);
                    end else begin
                        remaining_d = cmd_count;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (!hold) begin
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            funsel_q    <= 2'b00;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            funsel_q    <= funsel_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Scoreboard bench for reg_cmd_sequencer: expected issues and post-command register
// values are queued by the stimulus and consumed by a negedge monitor.
module tb_reg_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_count;
    logic       hold;
    logic       abort;
    logic [1:0] reg_funsel;
    logic [3:0] reg_data;
    logic       reg_enable;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [5:0] exp_issue[$];
    logic [3:0] exp_done[$];
    logic [3:0] reg_model = 4'h0;

    reg_cmd_sequencer #(.N(4), .CW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .hold       (hold),
        .abort      (abort),
        .reg_funsel (reg_funsel),
        .reg_data   (reg_data),
        .reg_enable (reg_enable),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // downstream function-select register
    always @(posedge clk) begin
        if (reg_enable === 1'b1) begin
            case (reg_funsel)
                2'b00: reg_model <= reg_model - 4'd1;
                2'b01: reg_model <= reg_model + 4'd1;
                2'b10: reg_model <= reg_data;
                default: reg_model <= 4'h0;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] e;
        logic [3:0] r;
        if (reg_enable === 1'b1) begin
            if (exp_issue.size() == 0) begin
                check("unexpected issue", 1, 0);
            end else begin
                e = exp_issue.pop_front();
                check("issue funsel", int'(reg_funsel), int'(e[5:4]));
                check("issue data", int'(reg_data), int'(e[3:0]));
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("unexpected done", 1, 0);
            end else begin
                r = exp_done.pop_front();
                check("register after done", int'(reg_model), int'(r));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command in the current cycle and records the enable pattern until done.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] data,
                           input logic [3:0] cnt, input logic [15:0] hold_pat,
                           input int exp_len, input logic [15:0] exp_en, input logic [3:0] exp_reg);
        logic [15:0] en;
        int len;
        en  = '0;
        len = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt; hold = 1'b0;
        #1;
        check({name, " ready"}, int'(cmd_ready), 1);
        for (int k = 0; k < $countones(exp_en); k++) exp_issue.push_back({op, data});
        exp_done.push_back(exp_reg);
        for (int i = 0; i < 20; i++) begin
            step();
            cmd_valid = 1'b0;
            hold = hold_pat[i];
            #1;
            if (done === 1'b1) begin
                len  = i;
                hold = 1'b0;
                break;
            end
            en[i] = reg_enable;
        end
        check({name, " issue cycles"}, len, exp_len);
        check({name, " enable pattern"}, int'(en), int'(exp_en));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'hF; cmd_count = 4'd3;
        hold = 1'b0; abort = 1'b0;
        step();
        step();
        check("reset ready", int'(cmd_ready), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset enable", int'(reg_enable), 0);
        check("reset funsel", int'(reg_funsel), 0);
        check("reset data", int'(reg_data), 0);
        rst = 1'b0; cmd_valid = 1'b0;
        step();
        check("idle after reset busy", int'(busy), 0);

        // each command is presented in the done cycle of the previous one
        run_cmd("load",   2'b10, 4'b0010, 4'd7, 16'h0000, 1, 16'b1,      4'b0010);
        run_cmd("inc3",   2'b01, 4'b0010, 4'd3, 16'h0000, 3, 16'b111,    4'b0101);
        run_cmd("dec4h",  2'b00, 4'b0000, 4'd4, 16'b001100, 6, 16'b110011, 4'b0001);
        run_cmd("inc0",   2'b01, 4'b0100, 4'd0, 16'h0000, 1, 16'b1,      4'b0010);
        run_cmd("clear5", 2'b11, 4'b1010, 4'd5, 16'h0000, 1, 16'b1,      4'b0000);

        // abort after three issues
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h0; cmd_count = 4'd8;
        #1;
        check("abort ready", int'(cmd_ready), 1);
        repeat (3) exp_issue.push_back({2'b01, 4'h0});
        for (int i = 0; i < 3; i++) begin
            step();
            cmd_valid = 1'b0;
            #1;
            check("abort pre-issue", int'(reg_enable), 1);
        end
        step();
        abort = 1'b1;
        #1;
        check("abort cycle enable", int'(reg_enable), 0);
        check("abort cycle busy", int'(busy), 1);
        step();
        abort = 1'b0;
        #1;
        check("after abort ready", int'(cmd_ready), 1);
        check("after abort busy", int'(busy), 0);
        check("after abort register", int'(reg_model), 3);
        step();
        check("no done after abort", int'(done), 0);

        // abort in IDLE must not block acceptance; reset after three issues
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h0; cmd_count = 4'd8; abort = 1'b1;
        #1;
        check("idle abort ready", int'(cmd_ready), 1);
        // the reset cycle is still an ISSUE cycle, so it issues a fourth time
        repeat (4) exp_issue.push_back({2'b01, 4'h0});
        step();
        cmd_valid = 1'b0; abort = 1'b0;
        #1;
        check("idle abort accepted", int'(busy), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check("rst pre-issue", int'(reg_enable), 1);
        end
        step();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'hF;
        #1;
        check("rst cycle ready", int'(cmd_ready), 0);
        step();
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        check("post-rst funsel", int'(reg_funsel), 0);
        check("post-rst data", int'(reg_data), 0);
        check("post-rst busy", int'(busy), 0);
        check("post-rst done", int'(done), 0);
        check("post-rst enable", int'(reg_enable), 0);
        check("post-rst ready", int'(cmd_ready), 1);
        check("post-rst register", int'(reg_model), 7);
        step();
        step();
        check("issue queue drained", exp_issue.size(), 0);
        check("done queue drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
